async_fifo_core: RTL and testbench
==================================

Name: async_fifo_core

Overview:
- Single-clock first-in-first-out buffer of WIDTH-bit words, DEPTH entries deep, with full and empty status flags.
- Sits between a producer and a consumer that share one clock, decoupling their burst timing.
- The read path is registered: data appears on rd_data on the clock edge after an accepted read.

Parameters:
- DEPTH, 8: number of storage entries; must be a power of two and at least 2.
- WIDTH, 8: data word width in bits.
- ADDR_W, $clog2(DEPTH): derived pointer index width; local, not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all control state immediately.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data, sampled on clk when a write is accepted.
- rd_en  input  1  read request.
- rd_data  output  WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when no entries are stored.

Behaviour:
- Reset, while rst is high: wr_ptr = 0, rd_ptr = 0, rd_data = 0, empty = 1, full = 0. Storage array contents are not reset.
- Pointers are ADDR_W+1 bits wide. The low ADDR_W bits index storage; the MSB is a wrap bit.
- empty is asserted when wr_ptr == rd_ptr.
- full is asserted when the MSBs of the two pointers differ and the low ADDR_W bits are equal.
- Both flags are decoded combinationally from the registered pointers, so they change one cycle after the accepted access that causes the change.
- Write acceptance, wr_ok = wr_en && !full:
  - mem[wr_ptr[ADDR_W-1:0]] <= wr_data.
  - wr_ptr increments by 1, modulo 2^(ADDR_W+1).
- Read acceptance, rd_ok = rd_en && !empty:
  - rd_data <= mem[rd_ptr[ADDR_W-1:0]].
  - rd_ptr increments by 1.
  - Latency is 1 clock from rd_en to valid rd_data.
- When no read is accepted, rd_data holds its last value.
- Write while full: the write is dropped silently; pointers and storage are unchanged.
- Read while empty: the read is dropped; rd_data holds its value.
- Simultaneous accepted read and write: both occur in the same cycle and the occupancy is unchanged.
  - Full with both requests: the read is accepted and the write is rejected, because full is evaluated on the current state.
  - Empty with both requests: the write is accepted and the read is rejected; there is no write-to-read bypass.
- Wrap-around: the index bits roll over from DEPTH-1 to 0 and the wrap bit toggles. Order is preserved across any number of wraps.
- Reset asserted mid-operation: pointers clear immediately and any stored data is discarded (FIFO reads as empty). Normal operation resumes on the first clock edge after rst deasserts.

Optional Feature:
- Macro: FIFO_LEVEL_EN.
- When defined:
  - Adds output port level [ADDR_W:0] = wr_ptr - rd_ptr, the current occupancy from 0 to DEPTH. It is 0 during reset.
  - Adds sticky outputs overflow and underflow, both 1 bit.
  - overflow sets on a write attempted while full.
  - underflow sets on a read attempted while empty.
  - Both clear only on rst.
- When undefined: these ports and their logic are absent. Behaviour is otherwise identical.

Decomposition:
- Package async_fifo_pkg holds:
  - the default DEPTH (8) and WIDTH (8) constants;
  - the ADDR_W derivation;
  - a pointer typedef, ptr_t, of ADDR_W+1 bits.
- One sub-module, fifo_mem: a DEPTH x WIDTH register array with a synchronous write port and a synchronous registered read port (write enable, write address, read enable, read address).
- Pointer and flag logic stays in async_fifo_core.

Test Plan:
- Reset: pulse rst high with no clock edge in between. Outputs must be empty = 1, full = 0, rd_data = 0 immediately, without waiting for a clock edge.
- Write then read:
  - Write 0xCC, then write 0xAA.
  - empty falls one cycle after the first write.
  - Assert rd_en for one cycle: rd_data = 0xCC on the next edge.
  - A second read gives 0xAA, after which empty = 1.
- Fill and overflow:
  - Hold wr_en high for 10 cycles with data 0x00 through 0x09.
  - full = 1 after the 8th write.
  - Reading 8 words returns 0x00 through 0x07; 0x08 and 0x09 were dropped.
- Underflow: assert rd_en on an empty FIFO for 3 cycles. rd_data must hold its prior value, empty stays 1, and pointers do not move.
- Simultaneous access: with 4 entries stored, assert wr_en and rd_en together for 20 cycles. Occupancy stays 4, the pointers wrap, and data order is intact.
- Mid-operation reset: write 5 words, then pulse rst. Expect empty = 1 and full = 0, and the next write/read pair returns the newly written word.

Source files
------------

// File: rtl/async_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO core.
// Holds the default geometry, the pointer-index width derivation and the
// pointer type for the default configuration.
package async_fifo_pkg;

    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_WIDTH = 8;

    // Index width needed to address every entry of a FIFO of the given depth.
    function automatic int addrWidth(input int depth);
        return $clog2(depth);
    endfunction

    localparam int DEFAULT_ADDR_W = addrWidth(DEFAULT_DEPTH);

    // Pointer for the default geometry: index bits plus one wrap bit on top.
    typedef logic [DEFAULT_ADDR_W:0] ptr_t;

endpackage

// File: rtl/async_fifo_core_fifo_mem.sv
// Storage for the FIFO: DEPTH x WIDTH register array with a synchronous
// write port and a registered read port. The read register is cleared by
// rst; the array itself is never reset.
module fifo_mem
    import async_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int ADDR_W = addrWidth(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    // Array write; contents survive reset since the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read register holds its value unless a read is accepted.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en_i) begin
            rd_data_d = mem_q[rd_addr_i];
        end
    end

    // Read data register, cleared to zero by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FIFO core: pointer bookkeeping and full/empty decode around
// the fifo_mem storage block.
// Optional feature macro FIFO_LEVEL_EN adds the occupancy output "level" and
// sticky "overflow"/"underflow" error flags.
module async_fifo_core
    import async_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int ADDR_W = addrWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
`ifdef FIFO_LEVEL_EN
    output logic [ADDR_W:0]  level,
    output logic             overflow,
    output logic             underflow,
`endif
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Pointers carry one extra MSB as a wrap bit so full and empty differ.
    logic [ADDR_W:0] wr_ptr_q;
    logic [ADDR_W:0] wr_ptr_d;
    logic [ADDR_W:0] rd_ptr_q;
    logic [ADDR_W:0] rd_ptr_d;
    logic            wrOk;
    logic            rdOk;

    // Flags decode from registered pointers only, so they lag the access by one edge.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        wrOk  = wr_en && !full;
        rdOk  = rd_en && !empty;
    end

    // Each pointer advances by one on its own accepted access, wrapping naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wrOk) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rdOk) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers; reset discards all stored entries by aligning the pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wrOk),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i (wr_data),
        .rd_en_i   (rdOk),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

`ifdef FIFO_LEVEL_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    // Error flags latch any rejected attempt and stay set until reset.
    always_comb begin
        overflow_d  = overflow_q  | (wr_en && full);
        underflow_d = underflow_q | (rd_en && empty);
    end

    // Sticky error flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign level     = wr_ptr_q - rd_ptr_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Self-checking bench for async_fifo_core (DEPTH=8, WIDTH=8).
// Table-driven vectors for basic traffic, fill/overflow and underflow, then
// hand-written sequences for simultaneous access, wrap, and resets.
// Extra checks on level/overflow/underflow when FIFO_LEVEL_EN is defined.
module tb_async_fifo_core;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
`ifdef FIFO_LEVEL_EN
    logic [3:0] level;
    logic       overflow;
    logic       underflow;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       wr;
        logic [7:0] data;
        logic       rd;
        logic [7:0] expRd;
        logic       expEmpty;
        logic       expFull;
        string      name;
    } vec_t;

    vec_t vecs[$];

    async_fifo_core #(
        .DEPTH (8),
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
`ifdef FIFO_LEVEL_EN
        .level     (level),
        .overflow  (overflow),
        .underflow (underflow),
`endif
        .full      (full),
        .empty     (empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void addVec(input logic wr, input logic [7:0] data, input logic rd,
                                   input logic [7:0] expRd, input logic expEmpty,
                                   input logic expFull, input string name);
        vec_t v;
        v.wr = wr;
        v.data = data;
        v.rd = rd;
        v.expRd = expRd;
        v.expEmpty = expEmpty;
        v.expFull = expFull;
        v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] expRd,
                               input logic expEmpty, input logic expFull);
        total++;
        if (rd_data !== expRd || empty !== expEmpty || full !== expFull) begin
            bad++;
            $display("[TB] FAIL %s: got rd_data=%h empty=%b full=%b, expected rd_data=%h empty=%b full=%b",
                     name, rd_data, empty, full, expRd, expEmpty, expFull);
        end
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of requests, then sample 1 time unit after the edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd);
        wr_en   = wr;
        wr_data = data;
        rd_en   = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Short reset pulse between edges; outputs must clear without a clock.
    task automatic pulseReset(input string name);
        rst = 1'b1;
        #2;
        checkOutput(name, 8'h00, 1'b1, 1'b0);
`ifdef FIFO_LEVEL_EN
        checkValue({name, "_level"}, int'(level), 0);
        checkValue({name, "_flags"}, int'({overflow, underflow}), 0);
`endif
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] e;

        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = 8'h00;

        // Basic write/read then underflow on an empty FIFO.
        addVec(1'b1, 8'hCC, 1'b0, 8'h00, 1'b0, 1'b0, "wrCC");
        addVec(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0, "wrAA");
        addVec(1'b0, 8'h00, 1'b1, 8'hCC, 1'b0, 1'b0, "rdCC");
        addVec(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1, 1'b0, "rdAA");
        for (int i = 0; i < 3; i++) begin
            addVec(1'b0, 8'h00, 1'b1, 8'hAA, 1'b1, 1'b0, $sformatf("underflow%0d", i));
        end
        // Ten writes into an 8-deep FIFO; the last two are dropped.
        for (int i = 0; i < 10; i++) begin
            d = 8'(i);
            addVec(1'b1, d, 1'b0, 8'hAA, 1'b0, (i >= 7), $sformatf("fill%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            e = 8'(i);
            addVec(1'b0, 8'h00, 1'b1, e, (i == 7), 1'b0, $sformatf("drain%0d", i));
        end

        #1;
        rst = 1'b1;
        #1;
        checkOutput("resetInit", 8'h00, 1'b1, 1'b0);
`ifdef FIFO_LEVEL_EN
        checkValue("resetInitLevel", int'(level), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] table vectors: %0d", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].wr, vecs[i].data, vecs[i].rd);
            checkOutput(vecs[i].name, vecs[i].expRd, vecs[i].expEmpty, vecs[i].expFull);
        end
`ifdef FIFO_LEVEL_EN
        checkValue("afterTableLevel", int'(level), 0);
        checkValue("afterTableOverflow", int'(overflow), 1);
        checkValue("afterTableUnderflow", int'(underflow), 1);
`endif

        // Four stored, then twenty cycles of simultaneous read and write.
        for (int i = 0; i < 4; i++) begin
            d = 8'(8'h10 + i);
            applyStimulus(1'b1, d, 1'b0);
            checkOutput($sformatf("pre%0d", i), 8'h07, 1'b0, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            d = 8'(8'h14 + i);
            e = 8'(8'h10 + i);
            applyStimulus(1'b1, d, 1'b1);
            checkOutput($sformatf("both%0d", i), e, 1'b0, 1'b0);
`ifdef FIFO_LEVEL_EN
            checkValue($sformatf("bothLevel%0d", i), int'(level), 4);
`endif
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'(8'h24 + i);
            applyStimulus(1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("post%0d", i), e, (i == 3), 1'b0);
        end

        // Full with both requests: read wins, write is rejected.
        for (int i = 0; i < 8; i++) begin
            d = 8'(8'h40 + i);
            applyStimulus(1'b1, d, 1'b0);
            checkOutput($sformatf("refill%0d", i), 8'h27, 1'b0, (i == 7));
        end
        applyStimulus(1'b1, 8'h99, 1'b1);
        checkOutput("fullBoth", 8'h40, 1'b0, 1'b0);
`ifdef FIFO_LEVEL_EN
        checkValue("fullBothLevel", int'(level), 7);
`endif
        applyStimulus(1'b1, 8'h48, 1'b0);
        checkOutput("refullAgain", 8'h40, 1'b0, 1'b1);
        pulseReset("rstWhileFull");

        // Empty with both requests: write accepted, read rejected, no bypass.
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkOutput("emptyBoth", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("emptyBothRead", 8'h5A, 1'b1, 1'b0);

        // Reset in the middle of traffic discards everything stored.
        for (int i = 0; i < 5; i++) begin
            d = 8'(8'h30 + i);
            applyStimulus(1'b1, d, 1'b0);
            checkOutput($sformatf("midWr%0d", i), 8'h5A, 1'b0, 1'b0);
        end
        pulseReset("rstMidOp");
        applyStimulus(1'b1, 8'h77, 1'b0);
        checkOutput("afterRstWr", 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("afterRstRd", 8'h77, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
